// File: rtl/fnd_scan_capture.sv
// rtl/fnd_scan_capture.sv - recovers BCD digits from a multiplexed active-low FND scan bus
// Optional FND_SCAN_DP_EN enables decimal-point recovery and the 7F -> 4'hA code.
module fnd_scan_capture #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DIGITS-1:0]     i_fnd_comm,
    input  logic [7:0]            i_fnd_font,
    input  logic                  i_clear,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_dp,
    output logic                  o_valid,
    output logic                  o_error,
    output logic                  o_timeout
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_FULL = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_PRE  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_HUNT, S_SETTLE, S_HELD} state_t;

    function automatic logic [3:0] f_decode(input logic [7:0] font);
        case (font[6:0])
            7'h40:   f_decode = 4'h0;
            7'h79:   f_decode = 4'h1;
            7'h24:   f_decode = 4'h2;
            7'h30:   f_decode = 4'h3;
            7'h19:   f_decode = 4'h4;
            7'h12:   f_decode = 4'h5;
            7'h02:   f_decode = 4'h6;
            7'h78:   f_decode = 4'h7;
            7'h00:   f_decode = 4'h8;
            7'h10:   f_decode = 4'h9;
            7'h7F:   f_decode = font[7] ? 4'hF : 4'hA;
            default: f_decode = 4'hE;
        endcase
    endfunction

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_to_cnt;
    logic [DIGITS-1:0]     r_comm;
    logic [DIGITS-1:0]     r_prev_comm;
    logic [7:0]            r_font;
    logic [7:0]            r_prev_font;
    logic [DIGITS-1:0]     r_seen;
    logic [4*DIGITS-1:0]   r_shadow;

    logic [7:0]            w_font_in;
    logic [DIGITS-1:0]     w_low;
    logic                  w_sel;
    logic                  w_same;
    logic                  w_capture;
    logic                  w_complete;
    logic                  w_err;
    logic [3:0]            w_code;

`ifdef FND_SCAN_DP_EN
    logic [DIGITS-1:0]     r_dp_shadow;
    logic [DIGITS-1:0]     r_dp_out;
    assign w_font_in = i_fnd_font;
    assign o_dp      = r_dp_out;
`else
    // With DP disabled the DP bit is forced off before it is ever stored.
    assign w_font_in = i_fnd_font | 8'h80;
    assign o_dp      = '0;
`endif

    assign w_low      = ~r_comm;
    assign w_sel      = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
    assign w_same     = (r_comm == r_prev_comm) && (r_font == r_prev_font);
    assign w_code     = f_decode(r_font);
    assign w_capture  = !i_clear && (r_state == S_SETTLE) && w_sel && w_same && (r_cnt == C_LAST);
    assign w_complete = !i_clear && (&r_seen);

    always_comb begin
        w_err = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_shadow[4*k +: 4] == 4'hE) w_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_HUNT;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_comm      <= '1;
            r_prev_comm <= '1;
            r_font      <= 8'hFF;
            r_prev_font <= 8'hFF;
            r_seen      <= '0;
            r_shadow    <= '1;
            o_bcd       <= '1;
            o_valid     <= 1'b0;
            o_error     <= 1'b0;
            o_timeout   <= 1'b0;
`ifdef FND_SCAN_DP_EN
            r_dp_shadow <= '0;
            r_dp_out    <= '0;
`endif
        end else begin
            r_comm      <= i_fnd_comm;
            r_font      <= w_font_in;
            r_prev_comm <= r_comm;
            r_prev_font <= r_font;
            o_valid     <= 1'b0;

            if (i_clear) begin
                r_state <= S_HUNT;
                r_cnt   <= '0;
                r_seen  <= '0;
            end else begin
                case (r_state)
                    S_HUNT: begin
                        if (w_sel) begin
                            r_state <= S_SETTLE;
                            r_cnt   <= C_ONE;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (!w_sel) begin
                            r_state <= S_HUNT;
                            r_cnt   <= '0;
                        end else if (!w_same) begin
                            r_cnt   <= C_ONE;
                        end else if (r_cnt == C_LAST) begin
                            r_state <= S_HELD;
                            r_cnt   <= C_FULL;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (!w_sel) begin
                            r_state <= S_HUNT;
                            r_cnt   <= '0;
                        end else if (!w_same) begin
                            r_state <= S_SETTLE;
                            r_cnt   <= C_ONE;
                        end
                    end
                endcase

                // A capture landing on the completion cycle starts the next frame.
                for (int k = 0; k < DIGITS; k++) begin
                    if (w_capture && w_low[k]) begin
                        r_seen[k]          <= 1'b1;
                        r_shadow[4*k +: 4] <= w_code;
`ifdef FND_SCAN_DP_EN
                        r_dp_shadow[k]     <= ~r_font[7];
`endif
                    end else if (w_complete) begin
                        r_seen[k]          <= 1'b0;
                    end
                end
            end

            if (w_complete) begin
                o_bcd   <= r_shadow;
                o_error <= w_err;
                o_valid <= 1'b1;
`ifdef FND_SCAN_DP_EN
                r_dp_out <= r_dp_shadow;
`endif
            end

            if (i_clear || w_complete) begin
                r_to_cnt  <= '0;
                o_timeout <= 1'b0;
            end else if (r_to_cnt != T_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt == T_PRE) o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_capture.sv
// tb/tb_fnd_scan_capture.sv - scoreboard bench for fnd_scan_capture
module tb_fnd_scan_capture;

    localparam int DIGITS  = 4;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 300;
`ifdef FND_SCAN_DP_EN
    localparam bit DPEN = 1'b1;
`else
    localparam bit DPEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  comm;
    logic [7:0]  font;
    logic        clr;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        valid;
    logic        err;
    logic        tmo;

    int tests = 0;
    int fails = 0;
    logic [20:0] sb[$];

    fnd_scan_capture #(
        .DIGITS(DIGITS),
        .STABLE_CYCLES(STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_fnd_comm(comm),
        .i_fnd_font(font),
        .i_clear(clr),
        .o_bcd(bcd),
        .o_dp(dp),
        .o_valid(valid),
        .o_error(err),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got bcd %0h expected no frame", bcd);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("frame_bcd", 32'(bcd), 32'(e[20:5]));
                chk("frame_dp",  32'(dp),  32'(e[4:1]));
                chk("frame_err", 32'(err), 32'(e[0]));
            end
        end
    end

    task automatic show(input logic [3:0] c, input logic [7:0] f, input int n);
        comm = c;
        font = f;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        clr = 1'b1;
        show(4'hF, 8'hFF, 1);
        clr = 1'b0;
        show(4'hF, 8'hFF, 2);
    endtask

    task automatic scan4(input logic [31:0] fonts, input int n);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] sel;
            sel = 4'hF;
            sel[k] = 1'b0;
            show(sel, fonts[8*k +: 8], n);
        end
    endtask

    initial begin
        logic [15:0] exp_hold;
        rst  = 1'b1;
        clr  = 1'b0;
        comm = 4'hF;
        font = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd", 32'(bcd), 32'hFFFF);
        chk("reset_dp", 32'(dp), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_error", 32'(err), 32'h0);
        chk("reset_timeout", 32'(tmo), 32'h0);
        rst = 1'b0;
        show(4'hF, 8'hFF, 2);

        // Basic scan 0..3
        sb.push_back({16'h3210, 4'b0000, 1'b0});
        scan4({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 8);
        show(4'hF, 8'hFF, 4);

        // Too-short holds: nothing captured, timeout eventually
        start_frame();
        for (int i = 0; i < 10; i++) scan4({8'hB0, 8'hA4, 8'hF9, 8'hC0}, STABLE - 2);
        chk("timeout_early", 32'(tmo), 32'h0);
        for (int i = 0; i < 30; i++) scan4({8'hB0, 8'hA4, 8'hF9, 8'hC0}, STABLE - 2);
        chk("timeout_set", 32'(tmo), 32'h1);

        // Ghost (two digits selected) then a valid scan
        show(4'b1100, 8'h99, 20);
        sb.push_back({16'h7654, 4'b0000, 1'b0});
        scan4({8'hF8, 8'h82, 8'h92, 8'h99}, 8);
        show(4'hF, 8'hFF, 4);
        chk("timeout_cleared", 32'(tmo), 32'h0);

        // Blank/DP font and an unrecognised font
        start_frame();
        exp_hold = DPEN ? 16'h3A1E : 16'h3F1E;
        sb.push_back({exp_hold, (DPEN ? 4'b0101 : 4'b0000), 1'b1});
        scan4({8'hB0, 8'h7F, 8'hF9, 8'h55}, 8);
        show(4'hF, 8'hFF, 4);

        // Clear coinciding with the last capture / completion
        start_frame();
        show(4'b1110, 8'hC0, 8);
        show(4'b1101, 8'hF9, 8);
        show(4'b1011, 8'hA4, 8);
        comm = 4'b0111;
        font = 8'hB0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("clear_hold_bcd", 32'(bcd), 32'(exp_hold));
        chk("clear_hold_err", 32'(err), 32'h1);
        start_frame();
        sb.push_back({16'h3210, 4'b0000, 1'b0});
        scan4({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 8);
        show(4'hF, 8'hFF, 4);

        // Reset mid-frame
        start_frame();
        show(4'b1110, 8'hC0, 8);
        show(4'b1101, 8'hF9, 8);
        rst = 1'b1;
        show(4'hF, 8'hFF, 2);
        rst = 1'b0;
        chk("midreset_bcd", 32'(bcd), 32'hFFFF);
        sb.push_back({16'h1098, 4'b0000, 1'b0});
        scan4({8'hF9, 8'hC0, 8'h90, 8'h80}, 8);
        show(4'hF, 8'hFF, 10);

        chk("pending_frames", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fnd_scan_capture.md
# fnd_scan_capture

Monitors the multiplexed common-anode FND drive bus (active-low digit select plus 8-bit active-low segment font) and recovers the displayed digits as BCD. Used in loopback self-test and in display readback, downstream of the FND scan driver. For each digit slot it waits until the select/font pair is stable and then decodes the font back to a 4-bit code. When every slot has been captured, it publishes one complete frame.

## Interface
Parameters:
- `DIGITS`, 4: number of multiplexed digits.
- `STABLE_CYCLES`, 4: consecutive identical samples required before a capture (≥2).
- `TIMEOUT_CYCLES`, 100000: cycles without a completed frame before `o_timeout` is asserted.

Ports:
- `i_clk`  in  1  clock. One clock domain. Reset is synchronous and active-high.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_fnd_comm`  in  DIGITS  digit select, active-low. Bit k low selects digit k.
- `i_fnd_font`  in  8  segment font, active-low. Bit 7 is DP, bits 6:0 are segments g..a.
- `i_clear`  in  1  one-cycle request to restart frame assembly.
- `o_bcd`  out  4*DIGITS  last complete frame. Digit k is in bits [4k+3:4k].
- `o_dp`  out  DIGITS  decimal point lit, per digit, last frame.
- `o_valid`  out  1  one-cycle pulse when `o_bcd`/`o_dp`/`o_error` update.
- `o_error`  out  1  the last frame contained an unrecognised font.
- `o_timeout`  out  1  sticky. No frame completed within `TIMEOUT_CYCLES`.

## Operation
- Input stage: `i_fnd_comm` and `i_fnd_font` are registered once. All logic works on the registered sample.
- Sample is "selectable" when exactly one bit of comm is low. Zero low bits or several low bits is ghosting/blanking and is never captured.
- FSM, one instance shared across digits:
  - HUNT: sample not selectable. Counter = 0. Goes to SETTLE on a selectable sample, with counter = 1.
  - SETTLE: if the sample equals the previous one, the counter increments. When the counter reaches `STABLE_CYCLES`, the block captures and goes to HELD. If the sample differs, the counter reloads to 1, or the FSM goes to HUNT if the sample is not selectable.
  - HELD: no recapture while the sample is unchanged. On any change, go to SETTLE (counter = 1) or HUNT.
- Capture writes the decoded code and DP into the shadow slot of the selected digit and sets that slot's seen bit. Recapturing a slot already seen this frame overwrites it.
- Font decode, bits 6:0:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F with DP lit (font 7F) → 4'hA.
  - 7F with DP off (font FF) → 4'hF, blank.
  - Anything else → 4'hE, which is an error.
- DP = ~font[7].
- Frame complete when all seen bits are set. On the next cycle:
  - shadow copies to `o_bcd`/`o_dp`;
  - `o_error` = OR of (slot == 4'hE);
  - `o_valid` = 1;
  - seen bits clear.
- Timeout counter:
  - cleared by `o_valid`, reset, or `i_clear`;
  - otherwise increments and saturates;
  - reaching `TIMEOUT_CYCLES` sets `o_timeout`;
  - `o_timeout` clears on the next `o_valid` or `i_clear`.
- `i_clear` clears seen bits, the FSM (to HUNT), the stability counter, the timeout counter and `o_timeout`. `o_bcd`, `o_dp` and `o_error` hold their values.
- Clear in the same cycle as frame completion: clear wins, and no `o_valid` is issued.

## Timing
- Reset values:
  - `o_bcd` = all 4'hF;
  - `o_dp` = 0;
  - `o_valid` = 0;
  - `o_error` = 0;
  - `o_timeout` = 0;
  - FSM in HUNT, seen bits 0, counters 0.
- A pair applied at input edge t is registered at t+1 and captured at t+`STABLE_CYCLES` if unchanged.
- When the last slot is captured at cycle c, `o_valid` is high at c+1, with outputs valid in that same cycle.
- Reset mid-frame discards partial captures. The first `o_valid` requires a fresh capture of all DIGITS slots.
- Minimum frame latency is DIGITS*`STABLE_CYCLES`+1 cycles from the first stable sample.
- Counter widths: stability counter is $clog2(`STABLE_CYCLES`+1) bits; timeout counter is $clog2(`TIMEOUT_CYCLES`+1) bits.

## Configuration
- `FND_SCAN_DP_EN` defined:
  - DP decoding is active as above;
  - font 7F decodes to 4'hA.
- `FND_SCAN_DP_EN` undefined:
  - font[7] is forced to 1 before decode, so 7F decodes to 4'hF;
  - `o_dp` is tied to 0;
  - DP storage is removed.

## Test plan
- Scan digits 0..3 with fonts C0,F9,A4,B0, 8 cycles each → one `o_valid`, `o_bcd`=16'h3210, `o_error`=0, `o_dp`=0.
- Hold each digit for only `STABLE_CYCLES`-2 cycles → no `o_valid`; `o_timeout`=1 after `TIMEOUT_CYCLES`.
- Comm 4'b1100 (two digits selected) for 20 cycles, mixed with a valid scan of 99,92,82,F8 → ghost sample ignored, `o_bcd`=16'h7654.
- Font 7F on digit 2 and 55 on digit 0 → `o_bcd`[11:8]=4'hA and `o_dp`[2]=1 (with `FND_SCAN_DP_EN`); `o_bcd`[3:0]=4'hE; `o_error`=1.
- `i_clear` in the same cycle as the last capture → no `o_valid`, outputs hold, and the next full scan produces `o_valid`.
- `i_reset` after 2 of 4 digits, then a full scan of 80,90,C0,F9 → exactly one `o_valid`, `o_bcd`=16'h1098.
